// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: iterative mult/div sequencer that owns hi/lo writes.
// 32-step shift-add multiply / restoring divide on operand magnitudes.
module hilo_muldiv_ctrl #(
   parameter int XLEN  = 32,
   parameter int STEPS = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [XLEN-1:0]   srca,
   input  logic [XLEN-1:0]   srcb,
   input  logic              mf_req,
   input  logic              mt_req,
   output logic              busy,
   output logic              stall,
   output logic              hilo_we,
   output logic [2*XLEN-1:0] hilo_wd,
   output logic              div_by_zero
);

   localparam int CW = $clog2(STEPS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [CW-1:0]       r_cnt;
   logic                r_is_div;
   logic                r_neg_res;
   logic                r_neg_dvd;
   logic                r_dbz;
   logic [XLEN-1:0]     r_opnd;
   logic [2*XLEN-1:0]   r_acc;
   logic [2*XLEN-1:0]   r_hilo_wd;

   logic                w_sgn;
   logic                w_a_neg;
   logic                w_b_neg;
   logic [XLEN-1:0]     w_a_mag;
   logic [XLEN-1:0]     w_b_mag;
   logic                w_div_zero;
   logic                w_last;
   logic [XLEN:0]       w_madd;
   logic [2*XLEN-1:0]   w_mstep;
   logic [XLEN:0]       w_rsh;
   logic                w_qbit;
   logic [XLEN-1:0]     w_diff;
   logic [2*XLEN-1:0]   w_dstep;
   logic [2*XLEN-1:0]   w_fix;

   assign w_sgn      = ~op[0];
   assign w_a_neg    = w_sgn & srca[XLEN-1];
   assign w_b_neg    = w_sgn & srcb[XLEN-1];
   assign w_a_mag    = w_a_neg ? -srca : srca;
   assign w_b_mag    = w_b_neg ? -srcb : srcb;
   assign w_div_zero = op[1] & (srcb == '0);
   assign w_last     = (r_cnt == CW'(STEPS-1));

   // multiply step: {hi,lo} holds partial product over remaining multiplier
   assign w_madd  = {1'b0, r_acc[2*XLEN-1:XLEN]}
                  + (r_acc[0] ? {1'b0, r_opnd} : '0);
   assign w_mstep = {w_madd, r_acc[XLEN-1:1]};

   // divide step: {rem,quo} shifts left, quotient bit enters at lsb
   assign w_rsh   = r_acc[2*XLEN-1:XLEN-1];
   assign w_qbit  = (w_rsh >= {1'b0, r_opnd});
   assign w_diff  = w_rsh[XLEN-1:0] - r_opnd;
   assign w_dstep = {w_qbit ? w_diff : w_rsh[XLEN-1:0],
                     r_acc[XLEN-2:0], w_qbit};

   // sign restore: product negates as a whole, div fixes q and r apart
   always_comb begin
      w_fix = r_acc;
      if (!r_is_div) begin
         if (r_neg_res) w_fix = -r_acc;
      end else begin
         if (r_neg_dvd) w_fix[2*XLEN-1:XLEN] = -r_acc[2*XLEN-1:XLEN];
         if (r_neg_res) w_fix[XLEN-1:0] = -r_acc[XLEN-1:0];
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // next-state logic; divide by zero skips straight to the write cycle
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (start) w_next = w_div_zero ? S_DONE : S_RUN;
         S_RUN:  if (w_last) w_next = S_FIX;
         S_FIX:  w_next = S_DONE;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // operand capture, iteration and result latch
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt     <= '0;
         r_is_div  <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_dvd <= 1'b0;
         r_dbz     <= 1'b0;
         r_opnd    <= '0;
         r_acc     <= '0;
         r_hilo_wd <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cnt     <= '0;
                  r_is_div  <= op[1];
                  r_neg_res <= w_a_neg ^ w_b_neg;
                  r_neg_dvd <= w_a_neg;
                  r_dbz     <= w_div_zero;
                  r_opnd    <= op[1] ? w_b_mag : w_a_mag;
                  r_acc     <= {{XLEN{1'b0}},
                                op[1] ? w_a_mag : w_b_mag};
                  if (w_div_zero)
                     r_hilo_wd <= {srca, {XLEN{1'b1}}};
               end
            end
            S_RUN: begin
               r_cnt <= r_cnt + CW'(1);
               r_acc <= r_is_div ? w_dstep : w_mstep;
            end
            S_FIX: begin
               r_hilo_wd <= w_fix;
            end
            default: ;
         endcase
      end
   end

   // status and write strobe decode
   always_comb begin
      busy        = (r_state != S_IDLE);
      hilo_we     = (r_state == S_DONE);
      div_by_zero = (r_state == S_DONE) & r_dbz;
      stall       = busy & (start | mf_req | mt_req);
   end

   assign hilo_wd = r_hilo_wd;

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer that owns all writes to the 64-bit hi/lo special register pair.
- Accepts mult/multu/div/divu operands from the register-file read ports (srca/srcb) and runs a 32-step shift-add multiply or restoring divide.
- Writes {hi,lo} with a one-cycle write strobe.
- Stalls the single-cycle datapath whenever an instruction needs hi/lo or the unit while an operation is in flight.

Parameters:
- XLEN, 32, operand width; hi/lo write data is 2*XLEN.
- STEPS, 32, iteration count; must equal XLEN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  decoded mult/multu/div/divu in the current instruction; level, held while stalled.
- op  in  2  00 mult, 01 multu, 10 div, 11 divu.
- srca  in  XLEN  rs value (multiplicand / dividend).
- srcb  in  XLEN  rt value (multiplier / divisor).
- mf_req  in  1  current instruction is mfhi/mflo.
- mt_req  in  1  current instruction is mthi/mtlo.
- busy  out  1  operation in flight.
- stall  out  1  freeze pc and regfile write this cycle.
- hilo_we  out  1  one-cycle write strobe to hi/lo.
- hilo_wd  out  2*XLEN  {hi,lo} write data.
- div_by_zero  out  1  high with hilo_we when a div/divu had srcb==0.

Behaviour:
- Reset: state IDLE; busy, hilo_we and div_by_zero are 0; hilo_wd is 0; counter and working registers are cleared.
- Reset mid-operation: returns to IDLE on that edge. No hilo_we is issued for the aborted operation.
- States: IDLE, RUN, FIX, DONE.
- IDLE with start=1 at edge E0:
  - Capture operands.
  - For signed ops, capture |srca| and |srcb| and record the result sign and dividend sign.
  - Go to RUN with counter=0.
  - Divide-by-zero exception: if op is div/divu and srcb==0, go directly to DONE.
- RUN, one step per cycle:
  - Multiply: shift-add on a 2*XLEN accumulator.
  - Divide: restoring division; shift remainder left, trial subtract, set quotient bit.
  - Counter increments each cycle. At counter==STEPS-1, go to FIX.
- FIX, one cycle:
  - Signed mult: if result sign is negative, take the two's complement of the full 64-bit product.
  - Signed div: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - Unsigned ops pass through unchanged.
  - Go to DONE.
- DONE, one cycle:
  - hilo_we=1. Multiply: hilo_wd = {product[63:32], product[31:0]}. Divide: hilo_wd = {remainder, quotient}.
  - Divide by zero: hilo_wd = {srca_captured, 32'hFFFFFFFF}, with div_by_zero=1.
  - Go to IDLE.
- Latency: for a normal op accepted at E0, hilo_we is high in the cycle between E33 and E34, and the unit is IDLE after E34. For divide by zero, hilo_we is high between E0 and E1.
- Overflow: div 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0. This falls out of the magnitude algorithm; no special case is required.
- busy = (state != IDLE).
- stall = busy & (start | mf_req | mt_req), computed combinationally.
  - mf_req is stalled through DONE, so the new value is visible to mfhi/mflo on the cycle after DONE.
  - start while busy is not accepted. The held instruction is accepted on the first IDLE cycle.
- hilo_we and div_by_zero are high only in DONE.
- hilo_wd holds its last value outside DONE.
- The unit never writes hi/lo for mt_req; the mthi/mtlo path is external and is only gated by stall.

Test Plan:
- mult srca=0xFFFFFFFD (-3), srcb=7 -> hilo_we exactly once, 34 cycles after start. hilo_wd={0xFFFFFFFF,0xFFFFFFEB}. busy high for cycles 1..34.
- multu 0xFFFFFFFF x 0xFFFFFFFF -> hilo_wd={0xFFFFFFFE,0x00000001}. div_by_zero=0.
- div -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu 0x1234 / 0 -> hilo_we one cycle after start. hilo_wd={0x00001234,0xFFFFFFFF}, div_by_zero=1, busy high for one cycle only.
- Start a mult, then raise mf_req at cycle 5 and hold it -> stall=1 from cycle 5 through the DONE cycle, stall=0 on the following cycle. A second start held during busy is accepted only after IDLE; hilo_we pulses occur 34 cycles apart or more.
- Start a div, assert reset at cycle 10 -> busy=0 after that edge. No hilo_we occurs. A new start is accepted on the next cycle.
